// File: rtl/reaction_ctrl_pkg.sv
// Shared state type, LFSR constants and sizing helper for the reaction-timer controller.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    STIM,
    DONE,
    EARLY
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Bits needed to hold the longest pre-stimulus delay: min_ms + 2^rand_bits - 1.
  function automatic int delay_width(input int min_ms, input int rand_bits);
    int max_val;
    int n;
    max_val = min_ms + (1 << rand_bits) - 1;
    n = 1;
    for (int i = 1; i < 31; i++) begin
      if ((max_val >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/reaction_ctrl_if.sv
// Trial control and result bus between the button/display logic and reaction_ctrl.
// Inputs are single-cycle edge pulses; outputs are registered levels plus a result pulse.
interface reaction_if #(
  parameter int RES_W = 14
);
  logic             start_rise;
  logic             resp_rise;
  logic             stim_led;
  logic             busy;
  logic [RES_W-1:0] result_ms;
  logic             result_valid;
  logic             early_fault;
  logic             timeout;

  modport slave (
    input  start_rise, resp_rise,
    output stim_led, busy, result_ms, result_valid, early_fault, timeout
  );

  modport master (
    output start_rise, resp_rise,
    input  stim_led, busy, result_ms, result_valid, early_fault, timeout
  );
endinterface

// File: rtl/reaction_ctrl_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV clocks, no flow control.
// clr restarts the count so the next tick is a full period away.
module ms_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer trial sequencer: random delay, stimulus, ms measurement, fault/timeout report.
// Outputs are registered and change one cycle after the sampled input pulse; no backpressure.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int CLK_HZ       = 100000000,
  parameter int TICK_DIV     = CLK_HZ / 1000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int MAX_MS       = 9999,
  parameter int RES_W        = 14
) (
  input logic      clk,
  input logic      rst_n,
  reaction_if.slave bus
);
  localparam int DLY_W = delay_width(MIN_DELAY_MS, RAND_BITS);

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q;
  logic [DLY_W-1:0] delay_q, delay_d;
  logic [RES_W-1:0] ms_q, ms_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             rvld_q, rvld_d;
  logic             early_q, early_d;
  logic             tmo_q, tmo_d;
  logic             tick;
  logic             tick_clr;

  // Restarting the prescaler on every state change keeps the first ms after entry full length.
  assign tick_clr = (state_d != state_q);

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    ms_d     = ms_q;
    result_d = result_q;
    rvld_d   = 1'b0;
    early_d  = early_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE, DONE, EARLY: begin
        if (bus.start_rise) begin
          state_d = ARM;
          delay_d = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q[RAND_BITS-1:0]);
          early_d = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      ARM: begin
        if (bus.resp_rise) begin
          state_d = EARLY;
          early_d = 1'b1;
        end else if (tick) begin
          // The tick that exhausts the delay also lights the stimulus.
          if (delay_q <= DLY_W'(1)) begin
            state_d = STIM;
            ms_d    = '0;
          end else begin
            delay_d = delay_q - DLY_W'(1);
          end
        end
      end
      STIM: begin
        if (bus.resp_rise) begin
          result_d = ms_q;
          rvld_d   = 1'b1;
          state_d  = DONE;
        end else if (tick) begin
          if (ms_q == RES_W'(MAX_MS)) begin
            result_d = RES_W'(MAX_MS);
            rvld_d   = 1'b1;
            tmo_d    = 1'b1;
            state_d  = DONE;
          end else begin
            ms_d = ms_q + RES_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_SEED;
      delay_q  <= '0;
      ms_q     <= '0;
      result_q <= '0;
      rvld_q   <= 1'b0;
      early_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      delay_q  <= delay_d;
      ms_q     <= ms_d;
      result_q <= result_d;
      rvld_q   <= rvld_d;
      early_q  <= early_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.stim_led     = (state_q == STIM);
  assign bus.busy         = (state_q == ARM) || (state_q == STIM);
  assign bus.result_ms    = result_q;
  assign bus.result_valid = rvld_q;
  assign bus.early_fault  = early_q;
  assign bus.timeout      = tmo_q;
endmodule

// File: tb/tb_reaction_ctrl.sv
// Randomized bench for reaction_ctrl against an arithmetic model of delay and ms count.
module tb_reaction_ctrl;
  localparam int CLK_HZ = 10000;
  localparam int TICK   = CLK_HZ / 1000;
  localparam int MIN_D  = 5;
  localparam int RB     = 3;
  localparam int MAXMS  = 50;
  localparam int RW     = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rv_count = 0;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  reaction_if #(.RES_W(RW)) bus ();

  reaction_ctrl #(
    .CLK_HZ(CLK_HZ), .MIN_DELAY_MS(MIN_D), .RAND_BITS(RB), .MAX_MS(MAXMS), .RES_W(RW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11, shifting left, seeded at reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  always @(posedge clk) if (bus.result_valid === 1'b1) rv_count <= rv_count + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit s, input bit r);
    bus.start_rise = s;
    bus.resp_rise  = r;
    step(1);
    bus.start_rise = 1'b0;
    bus.resp_rise  = 1'b0;
  endtask

  function automatic int model_delay_clocks();
    return TICK * (MIN_D + int'(m_lfsr[RB-1:0]));
  endfunction

  task automatic wait_stim(output int k);
    k = 0;
    while (bus.stim_led !== 1'b1 && k < 2000) begin
      step(1);
      k++;
    end
  endtask

  task automatic wait_valid(output int j);
    j = 0;
    while (bus.result_valid !== 1'b1 && j < 2000) begin
      step(1);
      j++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start_rise = 1'b0;
    bus.resp_rise  = 1'b0;
    step(2);
    n_cmp++;
    if ({bus.stim_led, bus.busy, bus.result_valid, bus.early_fault, bus.timeout} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 00000",
               {bus.stim_led, bus.busy, bus.result_valid, bus.early_fault, bus.timeout});
    end
    n_cmp++;
    if (bus.result_ms !== RW'(0)) begin
      n_err++; $display("FAIL reset_result: got %0d want 0", bus.result_ms);
    end
    rst_n = 1'b1;
    step(2);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_reaction(input int trials);
    int exp_clk, k, r, exp_ms;
    for (int t = 0; t < trials; t++) begin
      step($urandom_range(0, 15));
      exp_clk = model_delay_clocks();
      pulse(1'b1, 1'b0);
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.stim_led !== 1'b0) begin
        n_err++; $display("FAIL arm_entry: busy=%b stim=%b want 1 0", bus.busy, bus.stim_led);
      end
      wait_stim(k);
      n_cmp++;
      if (k != exp_clk) begin n_err++; $display("FAIL stim_delay: got %0d clocks want %0d", k, exp_clk); end
      r = (t == 0) ? 235 : int'($urandom_range(2, 400));
      exp_ms = (r - 1) / TICK;
      step(r - 1);
      pulse(1'b0, 1'b1);
      n_cmp++;
      if (bus.result_valid !== 1'b1 || bus.result_ms !== RW'(exp_ms)) begin
        n_err++;
        $display("FAIL result: valid=%b ms=%0d want 1 %0d (r=%0d)", bus.result_valid, bus.result_ms, exp_ms, r);
      end
      n_cmp++;
      if (bus.stim_led !== 1'b0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
        n_err++;
        $display("FAIL done_levels: stim=%b busy=%b tmo=%b want 0 0 0", bus.stim_led, bus.busy, bus.timeout);
      end
      step(1);
      n_cmp++;
      if (bus.result_valid !== 1'b0 || bus.result_ms !== RW'(exp_ms)) begin
        n_err++; $display("FAIL valid_pulse: valid=%b ms=%0d want 0 %0d", bus.result_valid, bus.result_ms, exp_ms);
      end
    end
  endtask

  task automatic test_early;
    int exp_clk, k, rv, w;
    bit saw_stim;
    for (int t = 0; t < 2; t++) begin
      step($urandom_range(0, 10));
      pulse(1'b1, 1'b0);
      w = $urandom_range(1, TICK * MIN_D - 2);
      step(w - 1);
      rv = rv_count;
      pulse(t == 1, 1'b1);
      n_cmp++;
      if (bus.early_fault !== 1'b1 || bus.busy !== 1'b0 || bus.stim_led !== 1'b0) begin
        n_err++;
        $display("FAIL early_entry: early=%b busy=%b stim=%b want 1 0 0", bus.early_fault, bus.busy, bus.stim_led);
      end
      saw_stim = 1'b0;
      for (int i = 0; i < 150; i++) begin
        step(1);
        if (bus.stim_led === 1'b1) saw_stim = 1'b1;
      end
      n_cmp++;
      if (saw_stim || rv_count != rv) begin
        n_err++; $display("FAIL early_quiet: stim_seen=%b results=%0d want 0 0", saw_stim, rv_count - rv);
      end
    end
    exp_clk = model_delay_clocks();
    pulse(1'b1, 1'b0);
    n_cmp++;
    if (bus.early_fault !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL early_clear: early=%b busy=%b want 0 1", bus.early_fault, bus.busy);
    end
    wait_stim(k);
    n_cmp++;
    if (k != exp_clk) begin n_err++; $display("FAIL rearm_delay: got %0d want %0d", k, exp_clk); end
    step(40);
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_timeout;
    int k, j, exp_clk;
    pulse(1'b1, 1'b0);
    wait_stim(k);
    wait_valid(j);
    n_cmp++;
    if (j != TICK * (MAXMS + 1) || bus.result_ms !== RW'(MAXMS) || bus.timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout: at=%0d ms=%0d tmo=%b want %0d %0d 1", j, bus.result_ms, bus.timeout, TICK * (MAXMS + 1), MAXMS);
    end
    step(1);
    n_cmp++;
    if (bus.result_valid !== 1'b0 || bus.timeout !== 1'b1 || bus.stim_led !== 1'b0) begin
      n_err++; $display("FAIL timeout_hold: valid=%b tmo=%b stim=%b want 0 1 0", bus.result_valid, bus.timeout, bus.stim_led);
    end
    exp_clk = model_delay_clocks();
    pulse(1'b1, 1'b0);
    n_cmp++;
    if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b want 0", bus.timeout); end
    wait_stim(k);
    n_cmp++;
    if (k != exp_clk) begin n_err++; $display("FAIL tmo_rearm_delay: got %0d want %0d", k, exp_clk); end
    step(TICK * (MAXMS + 1) - 1);
    pulse(1'b0, 1'b1);
    n_cmp++;
    if (bus.result_valid !== 1'b1 || bus.result_ms !== RW'(MAXMS) || bus.timeout !== 1'b0) begin
      n_err++;
      $display("FAIL resp_at_limit: valid=%b ms=%0d tmo=%b want 1 %0d 0", bus.result_valid, bus.result_ms, bus.timeout, MAXMS);
    end
  endtask

  task automatic test_back_to_back;
    logic [RW-1:0] old_ms;
    int exp_clk, k, e;
    step(3);
    old_ms = bus.result_ms;
    exp_clk = model_delay_clocks();
    pulse(1'b1, 1'b1);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.result_ms !== old_ms || bus.result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL done_simul: busy=%b ms=%0d valid=%b want 1 %0d 0", bus.busy, bus.result_ms, bus.result_valid, old_ms);
    end
    wait_stim(k);
    n_cmp++;
    if (k != exp_clk) begin n_err++; $display("FAIL b2b_delay: got %0d want %0d", k, exp_clk); end
    e = 0;
    for (int i = 0; i < 3; i++) begin
      step(20);
      pulse(1'b1, 1'b0);
      e += 21;
    end
    n_cmp++;
    if (bus.stim_led !== 1'b1) begin n_err++; $display("FAIL stim_start_ignored: stim=%b want 1", bus.stim_led); end
    step(177 - 1 - e);
    pulse(1'b0, 1'b1);
    n_cmp++;
    if (bus.result_valid !== 1'b1 || bus.result_ms !== RW'(17)) begin
      n_err++; $display("FAIL stim_count: valid=%b ms=%0d want 1 17", bus.result_valid, bus.result_ms);
    end
  endtask

  task automatic test_reset_mid;
    int k, rv, exp_clk;
    pulse(1'b1, 1'b0);
    wait_stim(k);
    step(100);
    rv = rv_count;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.stim_led, bus.busy, bus.result_valid, bus.early_fault, bus.timeout} !== 5'b0 ||
        bus.result_ms !== RW'(0)) begin
      n_err++;
      $display("FAIL async_reset: flags=%b ms=%0d want 00000 0",
               {bus.stim_led, bus.busy, bus.result_valid, bus.early_fault, bus.timeout}, bus.result_ms);
    end
    step(1);
    rst_n = 1'b1;
    step(3);
    n_cmp++;
    if (rv_count != rv || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_quiet: results=%0d busy=%b want 0 0", rv_count - rv, bus.busy);
    end
    step($urandom_range(0, 7));
    exp_clk = model_delay_clocks();
    pulse(1'b1, 1'b0);
    wait_stim(k);
    n_cmp++;
    if (k != exp_clk) begin n_err++; $display("FAIL post_reset_delay: got %0d want %0d", k, exp_clk); end
  endtask

  initial begin
    test_reset();
    test_reaction(5);
    test_early();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/reaction_ctrl.md
Name: reaction_ctrl

Overview:
- Sequences one reaction-timer trial.
- Inputs are the single-cycle rising-edge pulses from the start and response button edge detectors.
- Waits a pseudo-random delay, then lights the stimulus and counts milliseconds until the response press.
- Reports the result, an early-press fault or a timeout to the display/readout logic.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- TICK_DIV, CLK_HZ/1000, clocks per millisecond tick.
- MIN_DELAY_MS, 1000, fixed part of the pre-stimulus delay.
- RAND_BITS, 11, width of the random delay addend (0..2^RAND_BITS-1 ms).
- MAX_MS, 9999, response timeout and maximum reported time.
- RES_W, 14, width of result_ms; must satisfy 2^RES_W > MAX_MS.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start_rise, input, 1, one-cycle pulse from the start-button edge detector.
- resp_rise, input, 1, one-cycle pulse from the response-button edge detector.
- stim_led, output, 1, stimulus lamp; high only in STIM.
- busy, output, 1, high in ARM or STIM.
- result_ms, output, RES_W, last measured reaction time in ms; held until the next result.
- result_valid, output, 1, one-cycle pulse when result_ms updates.
- early_fault, output, 1, level; set on entry to EARLY, cleared on the next accepted start.
- timeout, output, 1, level; set when a trial ends at MAX_MS, cleared on the next accepted start.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, counters 0, LFSR = 16'hACE1.
- Pulse handling: input pulses are sampled on the clk edge where they are high. The state change takes effect the same edge, so outputs change 1 cycle after the pulse.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-runs every clock in every state and never reaches all-zero.
- ms tick: prescaler counts 0..TICK_DIV-1 and pulses tick at TICK_DIV-1. It is cleared on every state entry, so the first ms after entry is full length.
- States:
  - IDLE: start_rise -> ARM. Load delay_ms = MIN_DELAY_MS + lfsr[RAND_BITS-1:0]. Clear early_fault and timeout.
  - ARM: decrement delay_ms on tick; when delay_ms == 0 on a tick -> STIM with ms_count = 0. resp_rise -> EARLY; this takes priority over a same-cycle tick. start_rise is ignored.
  - STIM: increment ms_count on tick. On resp_rise: result_ms <= ms_count (value before any same-cycle increment), result_valid pulse, -> DONE. If ms_count == MAX_MS on a tick: result_ms <= MAX_MS, result_valid pulse, timeout <= 1, -> DONE. resp_rise takes priority over a same-cycle timeout. start_rise is ignored.
  - DONE: start_rise -> ARM, identical to the IDLE transition. resp_rise is ignored.
  - EARLY: early_fault = 1. start_rise -> ARM, same as IDLE. resp_rise is ignored.
- Simultaneous start_rise and resp_rise:
  - In IDLE/DONE/EARLY: start wins and the response is discarded.
  - In ARM: EARLY.
  - In STIM: response is taken.
- Reset mid-trial: immediate return to reset values with stim_led low. No result_valid is generated.
- Width rules: ms_count saturates at MAX_MS and never wraps. delay_ms is wide enough for MIN_DELAY_MS + 2^RAND_BITS - 1.

Decomposition:
- Package reaction_pkg holds:
  - the state enum (IDLE, ARM, STIM, DONE, EARLY);
  - LFSR_SEED = 16'hACE1;
  - the LFSR tap mask;
  - a delay-width constant function.
- Sub-module ms_tick_gen (parameter TICK_DIV; ports clk, rst_n, clr, tick) is instantiated once.

Test Plan:
- Bench parameters: CLK_HZ=10000 (TICK_DIV=10), MIN_DELAY_MS=5, RAND_BITS=3, MAX_MS=50.
- Reset then start_rise: busy=1 next cycle. stim_led rises after exactly (5+lfsr[2:0])*10 clocks. Delay is checked against the reference LFSR model.
- Response 23 ticks after stim_led: result_ms=23, result_valid high exactly 1 cycle, stim_led=0, busy=0.
- resp_rise during ARM: early_fault=1, stim_led never rises, no result_valid. A following start_rise clears early_fault and begins a new ARM.
- No response: at ms_count=50 on a tick, result_ms=50, timeout=1, result_valid pulse. A same-cycle resp_rise instead gives result_ms=50 with timeout=0.
- start_rise and resp_rise together in DONE: new ARM entered, result_ms unchanged. Repeated start_rise during STIM: no effect on ms_count.
- rst_n low mid-STIM for 1 cycle: all outputs 0 immediately (asynchronously), state IDLE, no result_valid.
